// File: rtl/ps2_key_ctrl_if.sv
// ps2_key_ctrl_if: scancode input strobe, buffered key-event handshake and key-state outputs
interface ps2_key_ctrl_if #(parameter int AW = 3);
  logic          code_valid;
  logic [7:0]    code_data;
  logic          evt_valid;
  logic          evt_ready;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_break;
  logic          mod_shift;
  logic          mod_ctrl;
  logic          mod_alt;
  logic          caps_lock;
  logic [7:0]    press_cnt;
  logic [AW:0]   fifo_count;
  logic          overflow;
  modport master (
    output code_valid, code_data, evt_ready,
    input  evt_valid, evt_code, evt_ext, evt_break, mod_shift, mod_ctrl, mod_alt,
           caps_lock, press_cnt, fifo_count, overflow
  );
  modport slave (
    input  code_valid, code_data, evt_ready,
    output evt_valid, evt_code, evt_ext, evt_break, mod_shift, mod_ctrl, mod_alt,
           caps_lock, press_cnt, fifo_count, overflow
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: decodes E0/F0-prefixed scancodes into key events, tracks modifiers/caps, buffers events in a FIFO
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 3
) (
  input logic            clk,
  input logic            reset,
  ps2_key_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  state_t      r_state, w_next;
  logic        w_emit, w_ext, w_brk;
  logic [7:0]  w_b;
  logic        w_e0, w_f0, w_nul;
  logic [5:0]  r_held, w_match;
  logic        r_caps_held, r_caps, w_caps;
  logic [7:0]  r_press;
  logic [9:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic        r_ovf, w_pop, w_push, w_full;
  logic [9:0]  w_head;
  assign w_b   = bus.code_data;
  assign w_e0  = w_b == 8'hE0;
  assign w_f0  = w_b == 8'hF0;
  assign w_nul = w_b == 8'h00 || w_b == 8'hFF;
  always_comb begin
    w_next = r_state;
    w_emit = 1'b0;
    w_ext  = r_state == EXT || r_state == EXT_BRK;
    w_brk  = r_state == BRK || r_state == EXT_BRK;
    if (bus.code_valid)
      case (r_state)
        IDLE: begin
          w_next = w_e0 ? EXT : w_f0 ? BRK : IDLE;
          w_emit = !(w_e0 || w_f0 || w_nul || w_b == 8'hAA || w_b == 8'hE1);
        end
        EXT: begin
          w_next = w_f0 ? EXT_BRK : w_e0 ? EXT : IDLE;
          w_emit = !(w_e0 || w_f0 || w_nul);
        end
        BRK: begin
          w_next = w_f0 ? BRK : w_e0 ? EXT_BRK : IDLE;
          w_emit = !(w_e0 || w_f0 || w_nul);
        end
        default: begin
          w_next = (w_f0 || w_e0) ? EXT_BRK : IDLE;
          w_emit = !(w_e0 || w_f0 || w_nul);
        end
      endcase
  end
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  // held bits: {ralt, lalt, rctrl, lctrl, rshift, lshift}
  assign w_match = {w_ext && w_b == 8'h11, !w_ext && w_b == 8'h11,
                    w_ext && w_b == 8'h14, !w_ext && w_b == 8'h14,
                    !w_ext && w_b == 8'h59, !w_ext && w_b == 8'h12};
  assign w_caps  = w_emit && !w_ext && w_b == 8'h58;
  always_ff @(posedge clk)
    if (reset) begin
      r_held      <= '0;
      r_caps_held <= 1'b0;
      r_caps      <= 1'b0;
      r_press     <= '0;
    end else begin
      if (w_emit) r_held <= (r_held & ~w_match) | (w_match & {6{!w_brk}});
      if (w_caps) r_caps_held <= !w_brk;
      if (w_caps && !w_brk && !r_caps_held) r_caps <= ~r_caps;
      if (w_emit && w_brk) r_press <= r_press + 8'd1;
    end
  assign w_full = r_cnt == DEPTH;
  assign w_pop  = r_cnt != '0 && bus.evt_ready;
  assign w_push = w_emit && (!w_full || w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {w_ext, w_brk, w_b};
  always_ff @(posedge clk)
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= (w_push && !w_pop) ? r_cnt + (AW+1)'(1) :
               (!w_push && w_pop) ? r_cnt - (AW+1)'(1) : r_cnt;
      if (w_emit && w_full && !w_pop) r_ovf <= 1'b1;
    end
  assign w_head         = r_cnt != '0 ? r_mem[r_rp] : '0;
  assign bus.evt_valid  = r_cnt != '0;
  assign bus.evt_ext    = w_head[9];
  assign bus.evt_break  = w_head[8];
  assign bus.evt_code   = w_head[7:0];
  assign bus.mod_shift  = r_held[0] | r_held[1];
  assign bus.mod_ctrl   = r_held[2] | r_held[3];
  assign bus.mod_alt    = r_held[4] | r_held[5];
  assign bus.caps_lock  = r_caps;
  assign bus.press_cnt  = r_press;
  assign bus.fifo_count = r_cnt;
  assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: directed scancode stimulus with a queue scoreboard checked by an event monitor
module tb_ps2_key_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic [9:0] exp_q[$];
  ps2_key_ctrl_if #(.AW(3)) ifc();
  ps2_key_ctrl #(.FIFO_DEPTH(8), .AW(3)) dut (.clk(clk), .reset(reset), .bus(ifc));
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b);
    ifc.code_valid = 1'b1;
    ifc.code_data  = b;
    @(posedge clk);
    #1;
    ifc.code_valid = 1'b0;
  endtask
  task automatic key(input bit ext, input bit brk, input logic [7:0] c, input bit keep = 1'b1);
    if (ext) send(8'hE0);
    if (brk) send(8'hF0);
    send(c);
    if (keep) exp_q.push_back({ext, brk, c});
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!reset && ifc.evt_valid && ifc.evt_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL evt_unexpected: got %0h expected none", {ifc.evt_ext, ifc.evt_break, ifc.evt_code});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({ifc.evt_ext, ifc.evt_break, ifc.evt_code} !== e) begin
          n_fail++;
          $display("FAIL evt_order: got %0h expected %0h", {ifc.evt_ext, ifc.evt_break, ifc.evt_code}, e);
        end
      end
    end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    ifc.code_valid = 1'b0;
    ifc.code_data  = 8'h00;
    ifc.evt_ready  = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(5);
    chk("rst_valid", ifc.evt_valid, 0);
    chk("rst_count", ifc.fifo_count, 0);
    chk("rst_evt", {ifc.evt_ext, ifc.evt_break, ifc.evt_code}, 0);
    chk("rst_mods", {ifc.mod_shift, ifc.mod_ctrl, ifc.mod_alt, ifc.caps_lock}, 0);
    chk("rst_press", ifc.press_cnt, 0);
    chk("rst_ovf", ifc.overflow, 0);
    ifc.evt_ready = 1'b1;
    key(0, 0, 8'h1C);
    chk("lat_make", ifc.evt_valid, 1);
    key(0, 1, 8'h1C);
    chk("lat_break", ifc.evt_valid, 1);
    tick(2);
    chk("press_1", ifc.press_cnt, 1);
    key(1, 0, 8'h75);
    key(1, 1, 8'h75);
    tick(1);
    chk("press_2", ifc.press_cnt, 2);
    key(1, 0, 8'h12);
    chk("e0_12_noshift", ifc.mod_shift, 0);
    key(1, 1, 8'h12);
    key(0, 0, 8'h12);
    chk("lshift", ifc.mod_shift, 1);
    key(0, 0, 8'h59);
    chk("both_shift", ifc.mod_shift, 1);
    key(0, 1, 8'h12);
    chk("rshift_only", ifc.mod_shift, 1);
    key(0, 1, 8'h59);
    chk("shift_off", ifc.mod_shift, 0);
    key(1, 0, 8'h14);
    chk("rctrl", ifc.mod_ctrl, 1);
    key(1, 1, 8'h14);
    chk("rctrl_off", ifc.mod_ctrl, 0);
    key(0, 0, 8'h11);
    chk("lalt", ifc.mod_alt, 1);
    key(0, 1, 8'h11);
    chk("lalt_off", ifc.mod_alt, 0);
    key(0, 0, 8'h58);
    chk("caps_on", ifc.caps_lock, 1);
    key(0, 0, 8'h58);
    key(0, 0, 8'h58);
    chk("caps_typematic", ifc.caps_lock, 1);
    key(0, 1, 8'h58);
    key(0, 0, 8'h58);
    chk("caps_off", ifc.caps_lock, 0);
    key(0, 1, 8'h58);
    tick(3);
    chk("press_9", ifc.press_cnt, 9);
    chk("drained", ifc.fifo_count, 0);
    ifc.evt_ready = 1'b0;
    for (int i = 1; i <= 8; i++) key(0, 0, 8'(i));
    chk("ovf_pre", ifc.overflow, 0);
    key(0, 0, 8'h09, 1'b0);
    chk("full_count", ifc.fifo_count, 8);
    chk("ovf_set", ifc.overflow, 1);
    chk("head_hold", ifc.evt_code, 8'h01);
    ifc.evt_ready = 1'b1;
    tick(10);
    chk("drain_count", ifc.fifo_count, 0);
    ifc.evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) key(0, 0, 8'h21 + 8'(i));
    chk("refill_count", ifc.fifo_count, 8);
    ifc.evt_ready = 1'b1;
    key(0, 0, 8'h0A);
    chk("pushpop_full", ifc.fifo_count, 8);
    chk("ovf_sticky", ifc.overflow, 1);
    tick(12);
    chk("drain2_count", ifc.fifo_count, 0);
    send(8'hE0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst2_ovf", ifc.overflow, 0);
    chk("rst2_press", ifc.press_cnt, 0);
    key(0, 0, 8'h75);
    tick(2);
    for (int i = 0; i < 255; i++) key(0, 1, 8'h1C);
    tick(1);
    chk("press_255", ifc.press_cnt, 255);
    key(0, 1, 8'h1C);
    tick(1);
    chk("press_wrap", ifc.press_cnt, 0);
    tick(3);
    chk("sb_empty", exp_q.size(), 0);
    chk("end_valid", ifc.evt_valid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
